// File: rtl/sl_rx_buffered.sv
// Serial-line receiver: decodes the two-wire SL line, checks length/odd parity and buffers
// good words in a show-ahead FIFO. Define SL_RX_GAP_TIMEOUT_EN to build the inter-bit gap timeout.
module sl_rx_buffered #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STROB_POS    = 3,
    parameter int unsigned BIT_END_MAX  = 32,
    parameter int unsigned GAP_MAX      = 64,
    parameter int unsigned CONFIG_WIDTH = 16,
    parameter int unsigned STATUS_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_line_zeroes_a,
    input  logic                    serial_line_ones_a,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    wr_enable,
    input  logic                    clr_flags,
    input  logic                    rd_en,
    output logic [31:0]             data_w,
    output logic [STATUS_WIDTH-1:0] status_w,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    output logic                    irq
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BCW = (($clog2(DATA_WIDTH + 2) > 6) ? $clog2(DATA_WIDTH + 2) : 6) + 1;
    localparam int unsigned CCW = $clog2(BIT_END_MAX + 1) + 1;
    localparam logic [BCW-1:0] BitCntMax = BCW'(DATA_WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StDetect, StWaitEnd, StErr} state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_z_meta, r_z_sync, r_o_meta, r_o_sync;
    logic [7:0]            r_z_hist, r_o_hist;
    logic [CCW-1:0]        r_cycle_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [DATA_WIDTH:0]   r_shift, w_shift_d, w_par_mask;
    logic [DATA_WIDTH-1:0] w_data_mask, r_push_data;
    logic                  r_push_pend, r_wrp, r_wlc, r_pef, r_lef, r_ovf, r_irq;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic w_bit_start, w_bit_end, w_strobe, w_bit0, w_bit1, w_stop, w_start, w_word_end;
    logic w_len_ok, w_par_ok, w_set_wlc, w_set_pef, w_set_lef, w_gap_to;
    logic w_pop, w_push, w_full, w_ovf_set, w_cfg_ok, w_irq_d;
    logic [5:0] w_bq, w_wr_bq;

    assign w_bq    = r_config_w[6:1];
    assign w_wr_bq = wr_config_w[6:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_meta <= 1'b1;
            r_z_sync <= 1'b1;
            r_o_meta <= 1'b1;
            r_o_sync <= 1'b1;
            r_z_hist <= 8'hFF;
            r_o_hist <= 8'hFF;
        end else begin
            r_z_meta <= serial_line_zeroes_a;
            r_z_sync <= r_z_meta;
            r_o_meta <= serial_line_ones_a;
            r_o_sync <= r_o_meta;
            r_z_hist <= {r_z_hist[6:0], r_z_sync};
            r_o_hist <= {r_o_hist[6:0], r_o_sync};
        end
    end

    assign w_bit_start = (r_z_hist == 8'hF0) || (r_o_hist == 8'hF0);
    assign w_bit_end   = (r_z_hist[3:0] == 4'hF) && (r_o_hist[3:0] == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:    if (w_bit_start) w_state_nxt = StDetect;
            StDetect:  if (w_strobe) w_state_nxt = (r_z_sync && r_o_sync) ? StErr : StWaitEnd;
            StWaitEnd: begin
                if (w_bit_end)                              w_state_nxt = StIdle;
                else if (r_cycle_cnt >= CCW'(BIT_END_MAX)) w_state_nxt = StErr;
            end
            StErr:     w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_start   = (r_state == StIdle) && w_bit_start;
        w_strobe  = (r_state == StDetect) && (r_cycle_cnt == CCW'(STROB_POS));
        w_bit0    = w_strobe && !r_z_sync && r_o_sync;
        w_bit1    = w_strobe && r_z_sync && !r_o_sync;
        w_stop    = w_strobe && !r_z_sync && !r_o_sync;
        w_set_lef = (r_state == StErr);
    end

    always_comb begin
        w_data_mask = '0;
        w_par_mask  = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) w_data_mask[i] = (i < int'(w_bq));
        for (int i = 0; i <= int'(DATA_WIDTH); i++) w_par_mask[i] = (i <= int'(w_bq));
    end

    // Parity bit lands at index BQ, so odd parity is the XOR over bits [BQ:0].
    assign w_len_ok   = (r_bit_cnt == ({{(BCW-6){1'b0}}, w_bq} + BCW'(1)));
    assign w_par_ok   = !r_config_w[0] || (^(r_shift & w_par_mask));
    assign w_set_wlc  = (w_stop && !w_len_ok) || w_gap_to;
    assign w_set_pef  = w_stop && w_len_ok && !w_par_ok;
    assign w_word_end = w_stop || w_set_lef || w_gap_to;

`ifdef SL_RX_GAP_TIMEOUT_EN
    localparam int unsigned GCW = $clog2(GAP_MAX + 1) + 1;
    logic [GCW-1:0] r_gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                    r_gap_cnt <= '0;
        else if (r_state == StIdle && r_bit_cnt != '0 && !w_gap_to) r_gap_cnt <= r_gap_cnt + GCW'(1);
        else                                                           r_gap_cnt <= '0;
    end

    assign w_gap_to = (r_state == StIdle) && (r_bit_cnt != '0) && (r_gap_cnt == GCW'(GAP_MAX));
`else
    assign w_gap_to = 1'b0;
`endif

    always_comb begin
        w_shift_d = r_shift;
        if (w_word_end) begin
            w_shift_d = '0;
        end else if (w_bit0 || w_bit1) begin
            for (int i = 0; i <= int'(DATA_WIDTH); i++) begin
                if (r_bit_cnt == BCW'(i)) w_shift_d[i] = w_bit1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wrp       <= 1'b0;
            r_push_pend <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_cycle_cnt <= (r_state == StDetect || r_state == StWaitEnd) ?
                           r_cycle_cnt + CCW'(1) : '0;
            if (w_word_end)                                        r_bit_cnt <= '0;
            else if ((w_bit0 || w_bit1) && r_bit_cnt != BitCntMax) r_bit_cnt <= r_bit_cnt + BCW'(1);
            r_shift <= w_shift_d;
            if (w_start)         r_wrp <= 1'b1;
            else if (w_word_end) r_wrp <= 1'b0;
            r_push_pend <= w_stop && w_len_ok && w_par_ok;
            r_push_data <= r_shift[DATA_WIDTH-1:0] & w_data_mask;
        end
    end

    // A full FIFO still accepts the push when a pop frees a slot in the same cycle.
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = rd_en && (r_count != '0);
    assign w_push    = r_push_pend && (!w_full || w_pop);
    assign w_ovf_set = r_push_pend && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    assign w_cfg_ok = wr_enable && !r_wrp && !w_wr_bq[0] && (int'(w_wr_bq) >= 8) &&
                      (int'(w_wr_bq) <= int'(DATA_WIDTH));

    assign w_irq_d = r_config_w[8] ?
                     ((r_count >= CW'(FIFO_DEPTH / 2)) || r_wlc || r_pef || r_lef || r_ovf) :
                     (r_push_pend || w_set_wlc || w_set_pef || w_set_lef || w_ovf_set);

    // Set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_config_w <= CONFIG_WIDTH'(16'h0010);
            r_wlc      <= 1'b0;
            r_pef      <= 1'b0;
            r_lef      <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_cfg_ok) r_config_w <= wr_config_w;
            r_wlc <= (r_wlc && !clr_flags) || w_set_wlc;
            r_pef <= (r_pef && !clr_flags) || w_set_pef;
            r_lef <= (r_lef && !clr_flags) || w_set_lef;
            r_ovf <= (r_ovf && !clr_flags) || w_ovf_set;
            r_irq <= w_irq_d;
        end
    end

    assign irq = r_irq;

    // Head word is zero-extended to the 32-bit data port.
    always_comb begin
        data_w = '0;
        if (r_count != '0) data_w[DATA_WIDTH-1:0] = r_mem[r_rd_ptr];
    end

    always_comb begin
        status_w          = '0;
        status_w[0]       = r_wlc;
        status_w[1]       = r_wrp;
        status_w[3]       = (r_count != '0);
        status_w[4]       = r_pef;
        status_w[5]       = r_lef;
        status_w[6]       = r_ovf;
        status_w[7]       = w_full;
        status_w[8 +: CW] = r_count;
    end

endmodule
